// File: rtl/ntt_stage_sched_if.sv
// Bus bundle between the NTT stage sequencer, coefficient memory and the top-level controller.
// With NTT_STAGE_SCHED_PERF_EN defined it also carries the 16-bit stall_cnt.
interface ntt_stage_sched_if #(
  parameter int LOGN = 8
);
  // rd_en/wr_en are plain strobes with no back-pressure: a pair is transferred in every
  // cycle its strobe is high. stall is the only flow control, honoured by the sequencer in RUN.
  logic            start;
  logic            stall;
  logic            rd_en;
  logic [LOGN-1:0] rd_addr0;
  logic [LOGN-1:0] rd_addr1;
  logic            wr_en;
  logic [LOGN-1:0] wr_addr0;
  logic [LOGN-1:0] wr_addr1;
  logic [LOGN-1:0] stage;
  logic            busy;
  logic            done;
  logic [1:0]      state_dbg;
`ifdef NTT_STAGE_SCHED_PERF_EN
  logic [15:0]     stall_cnt;
`endif

  modport master (
    input  start, stall,
    output rd_en, rd_addr0, rd_addr1, wr_en, wr_addr0, wr_addr1,
    output stage, busy, done, state_dbg
`ifdef NTT_STAGE_SCHED_PERF_EN
    , output stall_cnt
`endif
  );

  modport slave (
    output start, stall,
    input  rd_en, rd_addr0, rd_addr1, wr_en, wr_addr0, wr_addr1,
    input  stage, busy, done, state_dbg
`ifdef NTT_STAGE_SCHED_PERF_EN
    , input stall_cnt
`endif
  );
endinterface

// File: rtl/ntt_stage_sched.sv
// Stage/pair sequencer for an in-place radix-2 NTT: issues one pair read per cycle, delays it
// LAT cycles into the write strobe, and drains between stages. NTT_STAGE_SCHED_PERF_EN adds stall_cnt.
module ntt_stage_sched #(
  parameter int LOGN = 8,
  parameter int LAT  = 2
) (
  input logic               clk,
  input logic               reset,
  ntt_stage_sched_if.master bus
);
  localparam int JW = LOGN - 1;
  localparam int DW = $clog2(LAT + 1);
  localparam int PW = 2 * LOGN + 1;
  localparam logic [JW-1:0]   J_LAST     = '1;
  localparam logic [LOGN-1:0] STAGE_LAST = LOGN'(LOGN - 1);

  // IDLE is encoding 0 so state_dbg reads 0 while reset is held.
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_FIN   = 2'd3
  } state_e;

  state_e          state_q, state_d;
  logic [LOGN-1:0] stage_q, stage_d;
  logic [JW-1:0]   j_q, j_d;
  logic [DW-1:0]   drain_q, drain_d;
  logic            rd_fire;
  logic [LOGN-1:0] j_ext;
  logic [LOGN-1:0] span;
  logic [LOGN-1:0] addr0;
  logic [LOGN-1:0] rd_addr0_w;
  logic [LOGN-1:0] rd_addr1_w;
  logic [PW-1:0]   dl_q [LAT];

  always_comb begin
    state_d = state_q;
    stage_d = stage_q;
    j_d     = j_q;
    drain_d = drain_q;
    rd_fire = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          state_d = S_RUN;
          stage_d = '0;
          j_d     = '0;
        end
      end
      S_RUN: begin
        if (!bus.stall) begin
          rd_fire = 1'b1;
          j_d     = j_q + 1'b1;
          if (j_q == J_LAST) begin
            state_d = S_DRAIN;
            drain_d = DW'(LAT);
          end
        end
      end
      S_DRAIN: begin
        drain_d = drain_q - 1'b1;
        if (drain_q == DW'(1)) begin
          if (stage_q == STAGE_LAST) begin
            state_d = S_FIN;
          end else begin
            state_d = S_RUN;
            stage_d = stage_q + 1'b1;
            j_d     = '0;
          end
        end
      end
      S_FIN: begin
        state_d = S_IDLE;
        stage_d = '0;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Split j at bit 'stage': upper bits pick the block of size 2*span, lower bits the offset.
  always_comb begin
    j_ext = LOGN'(j_q);
    span  = LOGN'(1) << stage_q;
    addr0 = ((j_ext >> stage_q) << (stage_q + 1'b1)) | (j_ext & (span - 1'b1));
    rd_addr0_w = rd_fire ? addr0 : '0;
    rd_addr1_w = rd_fire ? (addr0 + span) : '0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      stage_q <= '0;
      j_q     <= '0;
      drain_q <= '0;
    end else begin
      state_q <= state_d;
      stage_q <= stage_d;
      j_q     <= j_d;
      drain_q <= drain_d;
    end
  end

  // The datapath never stalls, so the write-tracking line shifts every cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < LAT; k++) dl_q[k] <= '0;
    end else begin
      dl_q[0] <= {rd_fire, rd_addr0_w, rd_addr1_w};
      for (int k = 1; k < LAT; k++) dl_q[k] <= dl_q[k-1];
    end
  end

  assign bus.rd_en     = rd_fire;
  assign bus.rd_addr0  = rd_addr0_w;
  assign bus.rd_addr1  = rd_addr1_w;
  assign bus.wr_en     = dl_q[LAT-1][PW-1];
  assign bus.wr_addr0  = dl_q[LAT-1][PW-2:LOGN];
  assign bus.wr_addr1  = dl_q[LAT-1][LOGN-1:0];
  assign bus.stage     = stage_q;
  assign bus.busy      = (state_q == S_RUN) || (state_q == S_DRAIN);
  assign bus.done      = (state_q == S_FIN);
  assign bus.state_dbg = state_q;

`ifdef NTT_STAGE_SCHED_PERF_EN
  logic [15:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (state_q == S_IDLE && bus.start) begin
      stall_cnt_d = '0;
    end else if (state_q == S_RUN && bus.stall && stall_cnt_q != 16'hFFFF) begin
      stall_cnt_d = stall_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) stall_cnt_q <= '0;
    else       stall_cnt_q <= stall_cnt_d;
  end

  assign bus.stall_cnt = stall_cnt_q;
`endif
endmodule

// File: tb/tb_ntt_stage_sched.sv
// Randomized bench for ntt_stage_sched (LOGN=3, LAT=2) against a butterfly-list reference model.
// Define NTT_STAGE_SCHED_PERF_EN for both RTL and bench to also check stall_cnt.
`timescale 1ns/1ps
module tb_ntt_stage_sched;
  localparam int LOGN    = 3;
  localparam int LAT     = 2;
  localparam int N       = 1 << LOGN;
  localparam int HALF    = N / 2;
  localparam int PW      = 2 * LOGN;
  localparam int MAX_CYC = 4000;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  int   n_vec = 0;
  int   n_err = 0;
  int   cyc;

  logic [PW-1:0] exp_q[$];
  logic [PW:0]   hist_q[$];

  ntt_stage_sched_if #(.LOGN(LOGN)) bus ();

  ntt_stage_sched #(.LOGN(LOGN), .LAT(LAT)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // Butterflies of each stage in natural order: blocks of 2*span, pair (base+k, base+k+span).
  task automatic load_pairs();
    logic [PW-1:0] p;
    exp_q.delete();
    for (int s = 0; s < LOGN; s++) begin
      for (int base = 0; base < N; base += 2 << s) begin
        for (int k = 0; k < (1 << s); k++) begin
          p = {LOGN'(base + k), LOGN'(base + k + (1 << s))};
          exp_q.push_back(p);
        end
      end
    end
  endtask

  task automatic kick();
    @(negedge clk);
    bus.start = 1'b1;
    bus.stall = 1'($urandom_range(0, 1));
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_rd_en"}, bus.rd_en, 0);
    check({tag, "_rd_addr1"}, bus.rd_addr1, 0);
    check({tag, "_wr_en"}, bus.wr_en, 0);
    check({tag, "_busy"}, bus.busy, 0);
    check({tag, "_done"}, bus.done, 0);
  endtask

  // mode 0: no stall, 1: random stall, 2: one stall on 2nd issue of stage1,
  // 3: stall only outside issue windows, 4: exactly 5 stalls at the start of stage0
  task automatic run_body(input int mode, input bit hold, input int abort_at, output int cycles);
    int st = 0, issued = 0, drain = 0, stalls = 0, e_stage;
    bit issuing = 1'b1, fin = 1'b0, hit = 1'b0, e_rd, e_done, e_busy;
    logic [PW-1:0] pair;
    logic [PW:0]   h;
    load_pairs();
    hist_q.delete();
    for (int k = 0; k < LAT; k++) hist_q.push_back('0);
    cycles = 0;
    e_done = 1'b0;
    while (1) begin
      @(negedge clk);
      bus.start = hold;
      case (mode)
        1:       bus.stall = ($urandom_range(0, 3) == 0);
        2:       bus.stall = issuing && st == 1 && issued == 1 && !hit;
        3:       bus.stall = !issuing && ($urandom_range(0, 1) == 1);
        4:       bus.stall = issuing && stalls < 5;
        default: bus.stall = 1'b0;
      endcase
      #1;
      cycles++;
      e_rd = 1'b0; e_done = 1'b0; e_busy = !fin; e_stage = st; pair = '0;
      if (fin) begin
        e_done = 1'b1;
      end else if (issuing) begin
        if (bus.stall) begin
          stalls++;
          hit = 1'b1;
        end else begin
          e_rd = 1'b1;
          pair = exp_q.pop_front();
          issued++;
          if (issued == HALF) begin
            issuing = 1'b0;
            drain = LAT;
          end
        end
      end else begin
        drain--;
        if (drain == 0) begin
          if (st == LOGN - 1) fin = 1'b1;
          else begin
            st++;
            issued = 0;
            issuing = 1'b1;
          end
        end
      end
      check("rd_en", bus.rd_en, e_rd);
      if (e_rd) begin
        check("rd_addr0", bus.rd_addr0, pair[PW-1:LOGN]);
        check("rd_addr1", bus.rd_addr1, pair[LOGN-1:0]);
      end
      h = hist_q.pop_front();
      hist_q.push_back({e_rd, pair});
      check("wr_en", bus.wr_en, h[PW]);
      if (h[PW]) begin
        check("wr_addr0", bus.wr_addr0, h[PW-1:LOGN]);
        check("wr_addr1", bus.wr_addr1, h[LOGN-1:0]);
      end
      check("busy", bus.busy, e_busy);
      check("done", bus.done, e_done);
      check("stage", bus.stage, e_stage);
`ifdef NTT_STAGE_SCHED_PERF_EN
      if (cycles == 1) check("stall_cnt_clr", bus.stall_cnt, 0);
      if (e_done) check("stall_cnt", bus.stall_cnt, stalls);
`endif
      if (e_done || cycles == abort_at) break;
      if (cycles >= MAX_CYC) begin
        check("timeout", 1, 0);
        break;
      end
    end
    if (e_done) begin
      check("total_cycles", cycles, LOGN * (HALF + LAT) + 1 + stalls);
      check("pairs_left", exp_q.size(), 0);
    end
  endtask

  initial begin
    bus.start = 1'b0;
    bus.stall = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_quiet("rst");
    check("rst_state", bus.state_dbg, 0);
    @(negedge clk);
    reset = 1'b0;

    kick(); run_body(0, 1'b0, 0, cyc);
    check("plain_cycles", cyc, 19);
    kick(); run_body(2, 1'b0, 0, cyc);
    check("one_stall_cycles", cyc, 20);
    kick(); run_body(4, 1'b0, 0, cyc);

    // Abort in the middle of stage1 with an asynchronous reset between clock edges.
    kick(); run_body(1, 1'b0, 9, cyc);
    #2 reset = 1'b1;
    #1;
    check_quiet("abort");
    check("abort_stage", bus.stage, 0);
    check("abort_state", bus.state_dbg, 0);
    @(negedge clk);
    reset = 1'b0;
    bus.stall = 1'b0;
    repeat (6) begin
      @(negedge clk);
      #1;
      check_quiet("post_rst");
    end
    kick(); run_body(1, 1'b0, 0, cyc);

    // start held through the run: one transform, then an IDLE cycle before the next.
    kick(); run_body(3, 1'b1, 0, cyc);
    @(negedge clk);
    #1;
    check("held_idle_busy", bus.busy, 0);
    check("held_idle_rd_en", bus.rd_en, 0);
    check("held_idle_state", bus.state_dbg, 0);
    run_body(0, 1'b0, 0, cyc);

    for (int r = 0; r < 4; r++) begin
      kick(); run_body(1, 1'b0, 0, cyc);
    end
    repeat (4) begin
      @(negedge clk);
      bus.stall = 1'($urandom_range(0, 1));
      #1;
      check_quiet("tail_idle");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/ntt_stage_sched.md
Name: ntt_stage_sched

Overview:
- Sequencer for the NTT modular-add datapath. Walks every stage of an in-place radix-2 transform over N = 2^LOGN coefficients.
- Issues one coefficient-pair read per cycle to coefficient memory, and tracks each pair through the fixed-latency read + modular-add pipeline.
- Emits the matching write-back addresses when the result is ready.
- Enforces the stage-to-stage read-after-write barrier and reports busy/done to the top-level controller.

Parameters:
- LOGN, 8, log2 of transform length N. Legal range 2..12.
- LAT, 2, cycles from rd_en/rd_addr to the datapath result being valid at the write port (1 memory read + 1 registered modular add).

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  request a full transform. Sampled in IDLE only.
- stall  input  1  hold issue for this cycle (memory port busy). Honoured in RUN only.
- rd_en  output  1  read strobe for pair (rd_addr0, rd_addr1).
- rd_addr0  output  LOGN  lower index of pair.
- rd_addr1  output  LOGN  upper index of pair (rd_addr0 + span).
- wr_en  output  1  write strobe for datapath result.
- wr_addr0  output  LOGN  rd_addr0 delayed LAT cycles.
- wr_addr1  output  LOGN  rd_addr1 delayed LAT cycles.
- stage  output  LOGN  current stage index, 0..LOGN-1.
- busy  output  1  high in RUN and DRAIN.
- done  output  1  one-cycle pulse when the last write of the last stage has been issued.

Behaviour:
- Reset: asynchronous and active-high. While reset is high, all outputs are 0, the FSM is in IDLE, all counters are 0, and the delay line is cleared, so no stale wr_en appears after reset release.
- FSM states: IDLE, RUN, DRAIN, FIN.
  - IDLE, start=1 -> RUN, with stage=0 and butterfly counter j=0. Otherwise stay in IDLE.
  - RUN: when stall=0, drive rd_en=1 with addresses from (stage, j) and increment j. When stall=1, drive rd_en=0 and hold j.
  - RUN: after issuing j = N/2-1 -> DRAIN, with drain counter loaded to LAT.
  - DRAIN: rd_en=0, decrement the counter each cycle; stall is ignored. When the counter reaches 0: if stage = LOGN-1 -> FIN, else increment stage, set j=0 -> RUN.
  - FIN: done=1 for exactly one cycle -> IDLE.
- Address rule: span = 2^stage; rd_addr0 = (j >> stage) * 2*span + (j & (span-1)); rd_addr1 = rd_addr0 + span. Use shift/mask only, no multiplier. Widths are LOGN bits; results never exceed N-1.
- Write tracking: a LAT-deep shift register carries {rd_en, rd_addr0, rd_addr1} to {wr_en, wr_addr0, wr_addr1}. It always shifts, because the datapath does not stall. Stall bubbles therefore appear as wr_en=0 gaps.
- Barrier: the first read of stage s+1 occurs the cycle after the last wr_en of stage s. The memory is write-first, so no hazard results.
- Cycles per stage with no stalls: N/2 + LAT. The total from leaving IDLE to done is LOGN*(N/2+LAT) + 1 cycles.
- start while busy or in FIN is ignored; a request is not queued.
- stall asserted in IDLE, DRAIN or FIN has no effect.
- Reset mid-operation aborts the transform immediately. There is no done pulse, and no write strobes occur after the reset edge.

Optional Feature:
- Macro: NTT_STAGE_SCHED_PERF_EN.
- Defined: adds output stall_cnt (16 bits). It counts cycles in RUN with stall=1, clears on the IDLE->RUN transition, saturates at 16'hFFFF, and holds its value after done until the next start. Reset value is 0.
- Undefined: the port and counter are absent; all other behaviour is identical.

Test Plan:
- LOGN=3, LAT=2, single start pulse, no stall -> rd pairs are stage0 (0,1)(2,3)(4,5)(6,7), stage1 (0,2)(1,3)(4,6)(5,7), stage2 (0,4)(1,5)(2,6)(3,7). Each wr pair is identical and 2 cycles later. busy is high for 18 cycles and done pulses on cycle 19.
- Same config, stall=1 on the 2nd issue cycle of stage1 -> one rd_en gap and a matching wr_en gap 2 cycles later. No pair is skipped or duplicated. done is delayed to cycle 20.
- Barrier check: observe the last wr_en of stage0 (addresses 6,7) -> the first rd_en of stage1 (0,2) occurs on the next cycle, never earlier.
- Reset asserted asynchronously mid-stage1 -> all outputs are 0 immediately, no wr_en appears after release, and the FSM is in IDLE. A new start runs a complete, correct transform.
- start held high for the whole run and stall toggled during DRAIN -> only one transform executes, DRAIN length is unchanged, and a second transform starts only after returning to IDLE.
- PERF_EN build, 5 stalled RUN cycles injected -> stall_cnt = 5 after done. It clears to 0 on the next start.
